key_click_decoder: RTL and testbench

- Sits directly downstream of key_debounce and consumes its single-cycle key_flag press pulse.
- Classifies press bursts within a timing window as single, double or triple click.
- Emits one registered single-cycle pulse per classified burst to the mode/control logic.
- One clock domain (sys_clk, 50 MHz nominal). Asynchronous active-low reset sys_rst_n.

---
 rtl/key_click_decoder.sv | 161 ++++++++++++++++
 tb/tb_key_click_decoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/key_click_decoder.sv
// -----------------------------------------------------------------------------
// key_click_decoder
//
// Purpose:
//   Consumes the single-cycle debounced press pulse from key_debounce and
//   classifies each burst of presses as a single, double or triple click.
//   A press joins the open burst if it arrives within CNT_WIN+1 edges of the
//   previous press; a third press closes the burst at once as a triple click.
//   Exactly one registered one-cycle flag is emitted per classified burst.
//
// Optional feature (compile-time macro KEY_CLICK_HOLDOFF_EN):
//   When defined, every decision is followed by a HOLD lockout of CNT_HOLD+1
//   cycles during which key_flag is ignored and busy stays high.
//   When undefined, the HOLD state and hold counter are not built.
//
// Parameters:
//   CNT_WIN  - max gap (cycles) between presses of one burst
//   CNT_HOLD - lockout length after a decision (holdoff build only)
//
// Ports:
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   key_flag    in   one-cycle debounced press pulse
//   single_flag out  one-cycle pulse, burst of 1 press
//   double_flag out  one-cycle pulse, burst of 2 presses
//   triple_flag out  one-cycle pulse, burst of 3 presses
//   busy        out  high while a burst is open (or in holdoff)
// -----------------------------------------------------------------------------
module key_click_decoder #(
  parameter logic [23:0] CNT_WIN  = 24'd12_499_999,
  parameter logic [23:0] CNT_HOLD = 24'd2_499_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_flag,
  output logic single_flag,
  output logic double_flag,
  output logic triple_flag,
  output logic busy
);

`ifdef KEY_CLICK_HOLDOFF_EN
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;

  // CNT_HOLD only shapes the holdoff build; this empty block keeps the
  // parameter referenced so both builds share one parameter list.
  if (CNT_HOLD == 24'd0) begin : g_hold_param_ref
  end
`endif

  state_t      state, state_nxt;
  logic [1:0]  click_cnt, click_nxt;
  logic [23:0] win_cnt, win_nxt;
  logic        single_nxt, double_nxt, triple_nxt, busy_nxt;
  logic        decide;
`ifdef KEY_CLICK_HOLDOFF_EN
  logic [23:0] hold_cnt, hold_nxt;
`endif

  // ---- Stage: next-state and output decode --------------------------------
  always_comb begin
    state_nxt  = state;
    click_nxt  = click_cnt;
    win_nxt    = win_cnt;
    single_nxt = 1'b0;
    double_nxt = 1'b0;
    triple_nxt = 1'b0;
    decide     = 1'b0;
`ifdef KEY_CLICK_HOLDOFF_EN
    hold_nxt   = hold_cnt;
`endif

    case (state)
      IDLE: begin
        if (key_flag) begin
          click_nxt = 2'd1;
          win_nxt   = 24'd0;
          state_nxt = WAIT;
        end
      end

      WAIT: begin
        // A press wins over window expiry, so a press landing exactly on the
        // expiry edge still joins the burst.
        if (key_flag && (click_cnt == 2'd2)) begin
          triple_nxt = 1'b1;
          decide     = 1'b1;
        end else if (key_flag) begin
          click_nxt = click_cnt + 2'd1;
          win_nxt   = 24'd0;
        end else if (win_cnt == CNT_WIN) begin
          single_nxt = (click_cnt == 2'd1);
          double_nxt = (click_cnt == 2'd2);
          decide     = 1'b1;
        end else begin
          win_nxt = win_cnt + 24'd1;
        end
      end

`ifdef KEY_CLICK_HOLDOFF_EN
      HOLD: begin
        // key_flag is deliberately ignored here.
        if (hold_cnt == CNT_HOLD) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt + 24'd1;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase

    if (decide) begin
      click_nxt = 2'd0;
      win_nxt   = 24'd0;
`ifdef KEY_CLICK_HOLDOFF_EN
      hold_nxt  = 24'd0;
      state_nxt = HOLD;
`else
      state_nxt = IDLE;
`endif
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // ---- Stage: state and output registers ----------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      click_cnt   <= 2'd0;
      win_cnt     <= 24'd0;
      single_flag <= 1'b0;
      double_flag <= 1'b0;
      triple_flag <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      click_cnt   <= click_nxt;
      win_cnt     <= win_nxt;
      single_flag <= single_nxt;
      double_flag <= double_nxt;
      triple_flag <= triple_nxt;
      busy        <= busy_nxt;
    end
  end

`ifdef KEY_CLICK_HOLDOFF_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= 24'd0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// -----------------------------------------------------------------------------
// tb_key_click_decoder
//
// Directed bench for key_click_decoder with CNT_WIN=49, CNT_HOLD=9 and a
// 20 ns clock. Edges are numbered from 1 after each reset release; key_flag
// is set 1 ns after edge e-1 so that edge e samples it. Outputs are sampled
// 1 ns after each edge and compared as {single, double, triple, busy}
// against hand-derived event edges.
// -----------------------------------------------------------------------------
module tb_key_click_decoder;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_flag  = 1'b0;
  logic single_flag, double_flag, triple_flag, busy;

  int n_total = 0;
  int n_bad   = 0;

  key_click_decoder #(
    .CNT_WIN  (24'd49),
    .CNT_HOLD (24'd9)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_flag    (key_flag),
    .single_flag (single_flag),
    .double_flag (double_flag),
    .triple_flag (triple_flag),
    .busy        (busy)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got{s,d,t,busy}=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {single_flag, double_flag, triple_flag, busy};
  endfunction

  // Hold reset for two edges, check the reset state, then release 1 ns after
  // an edge so the next edge is edge 1.
  task automatic do_reset(input string name);
    sys_rst_n = 1'b0;
    key_flag  = 1'b0;
    @(posedge sys_clk);
    #1;
    check_eq({name, "/reset"}, outs(), 4'b0000);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  // Drive presses at edges p0..p3 and check every edge first..last.
  // s1/s2: single_flag edges, d: double_flag edge, t: triple_flag edge,
  // busy expected high on edges b0lo..b0hi and b1lo..b1hi. -1 = unused.
  task automatic run_edges(input string name, input int first, input int last,
                           input int p0, input int p1, input int p2, input int p3,
                           input int s1, input int s2, input int d, input int t,
                           input int b0lo, input int b0hi, input int b1lo, input int b1hi);
    logic [3:0] exp;
    for (int e = first; e <= last; e++) begin
      key_flag = (e == p0) || (e == p1) || (e == p2) || (e == p3);
      @(posedge sys_clk);
      #1;
      exp[3] = (e == s1) || (e == s2);
      exp[2] = (e == d);
      exp[1] = (e == t);
      exp[0] = ((e >= b0lo) && (e <= b0hi)) || ((e >= b1lo) && (e <= b1hi));
      check_eq($sformatf("%s/e%0d", name, e), outs(), exp);
    end
    key_flag = 1'b0;
  endtask

  initial begin
`ifndef KEY_CLICK_HOLDOFF_EN
    // 1: lone press -> single at 60, busy 10..59
    do_reset("single");
    run_edges("single", 1, 70, 10, -1, -1, -1, 60, -1, -1, -1, 10, 59, -1, -1);

    // 2: presses 10, 40 -> double at 90
    do_reset("double");
    run_edges("double", 1, 100, 10, 40, -1, -1, -1, -1, 90, -1, 10, 89, -1, -1);

    // 3: presses 10, 30, 50 -> triple on edge 50, idle afterwards
    do_reset("triple");
    run_edges("triple", 1, 120, 10, 30, 50, -1, -1, -1, -1, 50, 10, 49, -1, -1);

    // 4a: gap 51 -> two separate singles at 60 and 111
    do_reset("gap51");
    run_edges("gap51", 1, 120, 10, 61, -1, -1, 60, 111, -1, -1, 10, 59, 61, 110);

    // 4b: gap 50, press lands on expiry edge -> double at 110
    do_reset("gap50");
    run_edges("gap50", 1, 120, 10, 60, -1, -1, -1, -1, 110, -1, 10, 109, -1, -1);

    // 5: reset mid-burst discards it; a fresh press afterwards works
    do_reset("rst");
    run_edges("rst_pre", 1, 29, 10, -1, -1, -1, -1, -1, -1, -1, 10, 29, -1, -1);
    @(posedge sys_clk);           // edge 30
    sys_rst_n = 1'b0;
    #1;
    check_eq("rst/async_e30", outs(), 4'b0000);
    for (int k = 31; k <= 33; k++) begin
      @(posedge sys_clk);
      #1;
      check_eq($sformatf("rst/held_e%0d", k), outs(), 4'b0000);
    end
    sys_rst_n = 1'b1;
    run_edges("rst_post", 34, 95, 35, -1, -1, -1, 85, -1, -1, -1, 35, 84, -1, -1);
`else
    // Holdoff build: lone press -> single at 60, busy through the hold to 69
    do_reset("hold_single");
    run_edges("hold_single", 1, 80, 10, -1, -1, -1, 60, -1, -1, -1, 10, 69, -1, -1);

    // 6: triple at 30, press at 35 ignored in hold, busy low at 40
    do_reset("hold_triple");
    run_edges("hold_triple", 1, 100, 10, 20, 30, 35, -1, -1, -1, 30, 10, 39, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
